// File: rtl/parking_pkg.sv
// Shared definitions for the parking-indicator blink controller.
// Mode and state encodings plus a width helper used by the prescaler and burst counter.
package parking_pkg;

  localparam logic MODE_BURST     = 1'b0;
  localparam logic MODE_SUSTAINED = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BLINK = 1'b1
  } state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int width_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blink_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and flags the last count as the blink tick.
// One instance is shared by all channels so their blink phases stay aligned.
module blink_tick_gen
  import parking_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int                TICK_W    = width_min1(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] count_q, count_d;

  assign tick = (count_q == TICK_LAST);

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multi_blink_ctrl.sv
// Per-channel lamp blinker: a trigger rising edge starts a fixed BURST or a SUSTAINED blink.
// All channels share one prescaler tick; each channel runs its own IDLE/BLINK FSM.
module multi_blink_ctrl
  import parking_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int BLINK_TOGGLES = 6,
  parameter int TICK_DIV      = 25_000_000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] trig,
  input  logic [CHANNELS-1:0] mode,
  output logic [CHANNELS-1:0] light,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  localparam int               CNT_W    = width_min1(BLINK_TOGGLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TOGGLES - 1);

  logic tick;

  blink_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_ch
    state_e           state_q, state_d;
    logic             light_q, light_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             trig_q;
    logic             armed_q;
    logic             edge_hit;

    // A trigger already high across reset is not a new request; wait until it has been seen low.
    assign edge_hit = trig[gi] & ~trig_q & armed_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        state_q <= ST_IDLE;
        light_q <= 1'b0;
        cnt_q   <= '0;
        mode_q  <= MODE_BURST;
        done_q  <= 1'b0;
        trig_q  <= 1'b0;
        armed_q <= ~trig[gi];
      end else begin
        state_q <= state_d;
        light_q <= light_d;
        cnt_q   <= cnt_d;
        mode_q  <= mode_d;
        done_q  <= done_d;
        trig_q  <= trig[gi];
        armed_q <= armed_q | ~trig[gi];
      end
    end

    always_comb begin
      state_d = state_q;
      light_d = light_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      done_d  = 1'b0;
      if (edge_hit) begin
        state_d = ST_BLINK;
        light_d = 1'b1;
        cnt_d   = '0;
        mode_d  = mode[gi];
      end else begin
        case (state_q)
          ST_IDLE: begin
            light_d = 1'b0;
          end
          ST_BLINK: begin
            if (tick) begin
              if (mode_q == MODE_BURST) begin
                if (cnt_q == CNT_LAST) begin
                  light_d = 1'b0;
                  cnt_d   = '0;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
                end else begin
                  light_d = ~light_q;
                  cnt_d   = cnt_q + 1'b1;
                end
              end else if (trig[gi]) begin
                light_d = ~light_q;
                cnt_d   = '0;
              end else begin
                light_d = 1'b0;
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            light_d = 1'b0;
          end
        endcase
      end
    end

    assign light[gi] = light_q;
    assign busy[gi]  = (state_q == ST_BLINK);
    assign done[gi]  = done_q;
  end

endmodule
